glip_uart_tx_framed: RTL and testbench

GLIP_UART_TX_FRAMED -- requirements
Module: glip_uart_tx_framed

---
 rtl/glip_uart_pkg.sv | 16 +
 rtl/glip_uart_baud_tick.sv | 30 +++
 rtl/glip_uart_tx_framed.sv | 90 +++++++++
 tb/tb_glip_uart_tx_framed.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/glip_uart_pkg.sv
// glip_uart_pkg: parity modes, FSM state encodings and parity helper shared by UART tx and rx
package glip_uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic parity_bit(input logic [8:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction
endpackage

// File: rtl/glip_uart_baud_tick.sv
// glip_uart_baud_tick: bit-period down-counter; load restarts it, tick pulses on the last cycle of each period
module glip_uart_baud_tick #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] div,
    output logic         tick
);
    logic [W-1:0] per;
    logic [W-1:0] cnt;
    logic [W-1:0] ld;

    // a divisor of 0 behaves like 1: tick every cycle
    assign ld   = (div == '0) ? '0 : div - 1'b1;
    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            per <= '0;
            cnt <= '0;
        end else if (load) begin
            per <= ld;
            cnt <= ld;
        end else begin
            cnt <= tick ? per : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/glip_uart_tx_framed.sv
// glip_uart_tx_framed: framed UART transmitter with optional parity and 1/2 stop bits
module glip_uart_tx_framed
    import glip_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  divisor,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("glip_uart_tx_framed: DATA_WIDTH must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $error("glip_uart_tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("glip_uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    localparam logic       HAS_PAR  = (PARITY != PARITY_NONE);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] sh;
    logic                  par;
    logic [3:0]            bit_cnt;
    logic                  stop_cnt;
    logic                  tick;
    logic                  accept;
    logic                  last_stop;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign done      = (state == ST_STOP) && tick && last_stop;

    glip_uart_baud_tick #(.W(DIV_WIDTH)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .div  (divisor),
        .tick (tick)
    );

    // tx is registered with the level of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            sh       <= '0;
            par      <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else if (accept) begin
            state    <= ST_START;
            tx       <= 1'b0;
            sh       <= in_data;
            par      <= parity_bit(9'(in_data), PARITY);
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else if (tick && state != ST_IDLE) begin
            if (state == ST_START || (state == ST_DATA && bit_cnt != LAST_BIT)) begin
                state   <= ST_DATA;
                tx      <= sh[0];
                sh      <= sh >> 1;
                bit_cnt <= (state == ST_START) ? '0 : bit_cnt + 1'b1;
            end else if (state == ST_DATA && HAS_PAR) begin
                state <= ST_PARITY;
                tx    <= par;
            end else if (state == ST_DATA || state == ST_PARITY || !last_stop) begin
                state    <= ST_STOP;
                tx       <= 1'b1;
                stop_cnt <= (state == ST_STOP);
            end else begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_glip_uart_tx_framed.sv
// tb_glip_uart_tx_framed: scoreboard bench over four parameter configurations
module tb_glip_uart_tx_framed;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] divisor = '0;
    logic [7:0]  in_data = '0;
    logic [3:0]  valid_v = '0;
    logic [3:0]  ready_v, tx_v, busy_v, done_v;
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt [4] = '{default: 0};
    int          w, w2, w3, base;

    typedef struct {
        logic [127:0] tx;
        logic [127:0] dn;
        int           len;
    } frame_t;
    frame_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;

    glip_uart_tx_framed #(.DATA_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .divisor(divisor), .in_data(in_data), .in_valid(valid_v[0]),
        .in_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    glip_uart_tx_framed #(.DATA_WIDTH(8), .PARITY(2)) u1 (
        .clk(clk), .rst(rst), .divisor(divisor), .in_data(in_data), .in_valid(valid_v[1]),
        .in_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    glip_uart_tx_framed #(.DATA_WIDTH(8), .PARITY(1)) u2 (
        .clk(clk), .rst(rst), .divisor(divisor), .in_data(in_data), .in_valid(valid_v[2]),
        .in_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    glip_uart_tx_framed #(.DATA_WIDTH(7), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .divisor(divisor), .in_data(in_data[6:0]), .in_valid(valid_v[3]),
        .in_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    function automatic int cw(input int i);
        return (i == 3) ? 7 : 8;
    endfunction
    function automatic int cp(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction
    function automatic int cs(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int i, input logic [7:0] data, input int d);
        frame_t      f;
        logic [15:0] bits;
        int          de, nb, ones;
        de   = (d == 0) ? 1 : d;
        nb   = 1 + cw(i) + ((cp(i) != 0) ? 1 : 0) + cs(i);
        ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < cw(i); k++) begin
            bits[1 + k] = data[k];
            ones += int'(data[k]);
        end
        if (cp(i) != 0) bits[1 + cw(i)] = (cp(i) == 1) ? ~ones[0] : ones[0];
        f.len = de * nb;
        f.tx  = '0;
        f.dn  = '0;
        for (int c = 0; c <= f.len; c++) begin
            f.tx[c] = (c < f.len) ? bits[c / de] : 1'b1;
            f.dn[c] = (c == f.len - 1);
        end
        sb.push_back(f);
    endtask

    task automatic send(input int i, input logic [7:0] data, input int d);
        int n;
        in_data    = data;
        divisor    = 16'(d);
        valid_v[i] = 1'b1;
        push_frame(i, data, d);
        n = 0;
        while (!ready_v[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic mon(input int i, output int waited);
        frame_t       f;
        logic [127:0] ot, od;
        waited = 0;
        @(negedge clk);
        while (tx_v[i] !== 1'b0 && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 300) begin
            chk("start_timeout", 1, 0);
            return;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        f  = sb.pop_front();
        ot = '0;
        od = '0;
        chk("busy_start", busy_v[i], 1);
        for (int c = 0; c <= f.len; c++) begin
            ot[c] = tx_v[i];
            od[c] = done_v[i];
            if (c < f.len) @(negedge clk);
        end
        chk("frame_tx", ot, f.tx);
        chk("frame_done", od, f.dn);
        chk("gap_ready", ready_v[i], 1);
    endtask

    task automatic one(input int i, input logic [7:0] data, input int d);
        int wt;
        fork
            begin
                send(i, data, d);
                valid_v[i] = 1'b0;
            end
            mon(i, wt);
        join
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx_v, 4'hF);
        chk("rst_ready", ready_v, 4'hF);
        chk("rst_busy", busy_v, 4'h0);
        chk("rst_done", done_v, 4'h0);
        repeat (20) @(negedge clk);
        chk("idle_tx", tx_v, 4'hF);

        one(0, 8'hA5, 4);
        one(1, 8'h55, 3);
        one(2, 8'h55, 3);
        one(3, 8'h7F, 3);
        one(0, 8'h3C, 0);

        // divisor and data change while the frame is in flight
        fork
            begin
                send(0, 8'h96, 4);
                valid_v[0] = 1'b0;
                repeat (10) @(negedge clk);
                divisor = 16'd9;
                in_data = 8'h00;
            end
            mon(0, w);
        join

        base = done_cnt[0];
        fork
            begin
                send(0, 8'h01, 2);
                send(0, 8'hFE, 2);
                send(0, 8'h5A, 2);
                valid_v[0] = 1'b0;
            end
            begin
                mon(0, w);
                mon(0, w2);
                chk("b2b_gap2", w2, 0);
                mon(0, w3);
                chk("b2b_gap3", w3, 0);
            end
        join
        chk("b2b_dones", done_cnt[0] - base, 3);

        // abort during data bit 3 (cycles 16..19 of a D=4 frame)
        base       = done_cnt[0];
        in_data    = 8'h00;
        divisor    = 16'd4;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        chk("abort_start", tx_v[0], 0);
        repeat (17) @(negedge clk);
        chk("abort_bit3_busy", busy_v[0], 1);
        rst        = 1'b1;
        valid_v[0] = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        valid_v[0] = 1'b0;
        chk("abort_tx", tx_v[0], 1);
        chk("abort_ready", ready_v[0], 1);
        chk("abort_busy", busy_v[0], 0);
        repeat (50) @(negedge clk);
        chk("abort_no_done", done_cnt[0] - base, 0);
        chk("abort_idle_tx", tx_v[0], 1);
        one(0, 8'hC3, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
